// File: rtl/uart_tx_fifo_pkg.sv
// Shared sigma UART definitions: frame format, FSM states and board baud divisor.
// Used by both the transmit and receive paths.
package uart_tx_fifo_pkg;

    localparam int UART_DATA_W = 8;
    localparam int FRAME_BITS  = 10;
    localparam int BIT_IDX_W   = $clog2(UART_DATA_W);
    localparam int BAUD_CNT_W  = 16;

    localparam int BOARD_CLK_HZ = 100_000_000;
    localparam int BOARD_BAUD   = 115_200;

    // Nearest-integer divisor so small baud errors round rather than truncate.
    function automatic int calc_baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    localparam int DEFAULT_BAUD_DIV = calc_baud_div(BOARD_CLK_HZ, BOARD_BAUD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side byte handshake: a byte moves on a clock edge where tx_req_i && tx_ack_o.
// The producer drives the master modport, the UART transmitter takes the slave modport.
interface uart_tx_fifo_if;
    import uart_tx_fifo_pkg::*;

    logic                   tx_req_i;
    logic [UART_DATA_W-1:0] tx_data_i;
    logic                   tx_ack_o;

    modport master (
        output tx_req_i,
        output tx_data_i,
        input  tx_ack_o
    );

    modport slave (
        input  tx_req_i,
        input  tx_data_i,
        output tx_ack_o
    );

endinterface

// File: rtl/uart_byte_fifo.sv
// Synchronous first-word-fall-through FIFO; push is ignored when full, pop when empty.
// Full blocks a push even when a pop happens in the same cycle.
module uart_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                   clk_i,
    input  logic                   arst_n_i,
    input  logic                   push_i,
    input  logic [W-1:0]           push_dat_i,
    input  logic                   pop_i,
    output logic [W-1:0]           pop_dat_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] cnt_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o    = (cnt_q == CNT_W'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign cnt_o     = cnt_q;
    assign pop_dat_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a START/DATA/STOP serialiser.
// Start bit appears one cycle after a byte lands in an idle, empty FIFO; tx_ack_o = !full.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int  BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter int  FIFO_DEPTH = 16,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    uart_tx_fifo_if.slave    prod,
    output logic             tx_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] fifo_cnt_o
);

    localparam logic [BAUD_CNT_W-1:0] BAUD_RELOAD = BAUD_CNT_W'(BAUD_DIV - 1);

    uart_state_e            state_q, state_d;
    logic [BAUD_CNT_W-1:0]  baud_q, baud_d;
    logic [BIT_IDX_W-1:0]   bit_q, bit_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   tx_q, tx_d;

    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [UART_DATA_W-1:0] fifo_dat;
    logic [CNT_W-1:0]       fifo_cnt;

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (UART_DATA_W)
    ) u_fifo (
        .clk_i      (clk_i),
        .arst_n_i   (arst_n_i),
        .push_i     (prod.tx_req_i),
        .push_dat_i (prod.tx_data_i),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .cnt_o      (fifo_cnt)
    );

    assign prod.tx_ack_o = !fifo_full;
    assign tx_o          = tx_q;
    assign fifo_cnt_o    = fifo_cnt;
    assign busy_o        = (state_q != ST_IDLE) || (fifo_cnt != '0);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dat;
                    baud_d   = BAUD_RELOAD;
                    tx_d     = 1'b0;
                    state_d  = ST_START;
                end
            end

            ST_START: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_RELOAD;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q - BAUD_CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_q == BIT_IDX_W'(UART_DATA_W - 1)) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        bit_d   = bit_q + BIT_IDX_W'(1);
                        shift_d = {1'b0, shift_q[UART_DATA_W-1:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - BAUD_CNT_W'(1);
                end
            end

            ST_STOP: begin
                // Chain straight into the next start bit when more data is queued.
                if (baud_q == '0) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dat;
                        baud_d   = BAUD_RELOAD;
                        tx_d     = 1'b0;
                        state_d  = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q - BAUD_CNT_W'(1);
                end
            end

            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with BAUD_DIV=4, FIFO_DEPTH=4; a line monitor decodes
// frames independently of the DUT so byte order and frame spacing can be checked.
module tb_uart_tx_fifo;

    localparam int BAUD  = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * BAUD;

    logic       clk;
    logic       arst_n;
    logic       tx_o;
    logic       busy_o;
    logic [2:0] fifo_cnt_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int nacc   = 0;
    int nbusy  = 0;
    bit low_seen;

    logic [9:0] rx_q [$];
    int         st_q [$];
    logic [7:0] exp_b [6];

    uart_tx_fifo_if bus ();

    uart_tx_fifo #(
        .BAUD_DIV   (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i      (clk),
        .arst_n_i   (arst_n),
        .prod       (bus),
        .tx_o       (tx_o),
        .busy_o     (busy_o),
        .fifo_cnt_o (fifo_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Line monitor: samples each bit at its second cycle; drops frames cut by reset.
    initial begin : rx_mon
        forever begin
            @(negedge clk);
            if (arst_n && tx_o === 1'b0) begin
                logic [9:0] sh;
                bit         ok;
                int         t0;
                sh = '0;
                ok = 1'b1;
                t0 = cyc;
                for (int k = 0; k < FRAME; k++) begin
                    if (k % BAUD == 1) sh = {tx_o, sh[9:1]};
                    if (!arst_n) ok = 1'b0;
                    if (k < FRAME - 1) @(negedge clk);
                end
                if (ok) begin
                    rx_q.push_back(sh);
                    st_q.push_back(t0);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on the first start-bit cycle; checks every cycle of the frame.
    task automatic expect_frame(input logic [7:0] b, input string tag);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int k = 0; k < FRAME; k++) begin
            chk(tag, tx_o, bits[k / BAUD]);
            chk({tag, "_busy"}, busy_o, 1'b1);
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (busy_o && n < budget) begin
            n++;
            @(negedge clk);
        end
        chk("idle_timeout", busy_o, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_frames(input string tag, input int n);
        chk({tag, "_nframes"}, rx_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < rx_q.size()) begin
                chk({tag, "_frame"}, rx_q[i], {1'b1, exp_b[i], 1'b0});
                if (i > 0) chk({tag, "_gap"}, st_q[i] - st_q[i-1], FRAME);
            end
        end
    endtask

    task automatic run_push(input int n);
        logic a;
        for (int i = 0; i < n; i++) begin
            a = bus.tx_ack_o;
            @(negedge clk);
            if (a) begin
                nacc++;
                bus.tx_data_i = bus.tx_data_i + 8'd1;
            end
        end
    endtask

    initial begin
        // Reset with a pending request that must not be taken.
        arst_n        = 1'b0;
        bus.tx_req_i  = 1'b1;
        bus.tx_data_i = 8'h77;
        repeat (5) @(negedge clk);
        chk("rst_tx", tx_o, 1'b1);
        chk("rst_ack", bus.tx_ack_o, 1'b1);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_cnt", fifo_cnt_o, 3'd0);
        arst_n       = 1'b1;
        bus.tx_req_i = 1'b0;
        @(negedge clk);
        chk("rst_no_accept_cnt", fifo_cnt_o, 3'd0);
        chk("rst_no_accept_busy", busy_o, 1'b0);

        // Single byte 0xA5, cycle-exact waveform and busy release.
        rx_q.delete(); st_q.delete();
        bus.tx_req_i = 1'b1; bus.tx_data_i = 8'hA5;
        @(negedge clk);
        bus.tx_req_i = 1'b0;
        chk("a5_pre_tx", tx_o, 1'b1);
        chk("a5_pre_cnt", fifo_cnt_o, 3'd1);
        @(negedge clk);
        expect_frame(8'hA5, "a5_bit");
        chk("a5_busy_drop", busy_o, 1'b0);
        chk("a5_idle_tx", tx_o, 1'b1);
        repeat (2) @(negedge clk);
        exp_b[0] = 8'hA5;
        chk_frames("a5", 1);

        // Back-to-back 0x00, 0xFF.
        rx_q.delete(); st_q.delete();
        bus.tx_req_i = 1'b1; bus.tx_data_i = 8'h00;
        @(negedge clk);
        bus.tx_data_i = 8'hFF;
        @(negedge clk);
        bus.tx_req_i = 1'b0;
        wait_idle(200, nbusy);
        chk("b2b_busy_cycles", nbusy, 2 * FRAME);
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF;
        chk_frames("b2b", 2);

        // Full FIFO with request held and incrementing data.
        rx_q.delete(); st_q.delete();
        nacc = 0;
        bus.tx_req_i = 1'b1; bus.tx_data_i = 8'h10;
        run_push(6);
        chk("full_nacc", nacc, 5);
        chk("full_cnt", fifo_cnt_o, 3'd4);
        chk("full_ack", bus.tx_ack_o, 1'b0);
        run_push(35);
        chk("full_hold_nacc", nacc, 5);
        chk("full_hold_ack", bus.tx_ack_o, 1'b0);
        run_push(1);
        chk("full_pop_refused_cnt", fifo_cnt_o, 3'd3);
        chk("full_pop_ack", bus.tx_ack_o, 1'b1);
        chk("full_pop_nacc", nacc, 5);
        run_push(1);
        chk("full_refill_nacc", nacc, 6);
        chk("full_refill_cnt", fifo_cnt_o, 3'd4);
        bus.tx_req_i = 1'b0;
        wait_idle(400, nbusy);
        for (int i = 0; i < 6; i++) exp_b[i] = 8'h10 + 8'(i);
        chk_frames("full", 6);

        // Push lands in the STOP-expiry cycle while two bytes are queued.
        rx_q.delete(); st_q.delete();
        bus.tx_req_i = 1'b1; bus.tx_data_i = 8'h81;
        @(negedge clk);
        bus.tx_data_i = 8'h42;
        @(negedge clk);
        bus.tx_data_i = 8'h24;
        @(negedge clk);
        bus.tx_req_i = 1'b0;
        repeat (38) @(negedge clk);
        chk("pp_cnt_before", fifo_cnt_o, 3'd2);
        bus.tx_req_i = 1'b1; bus.tx_data_i = 8'h18;
        @(negedge clk);
        bus.tx_req_i = 1'b0;
        chk("pp_cnt_after", fifo_cnt_o, 3'd2);
        chk("pp_next_start", tx_o, 1'b0);
        wait_idle(300, nbusy);
        exp_b[0] = 8'h81; exp_b[1] = 8'h42; exp_b[2] = 8'h24; exp_b[3] = 8'h18;
        chk_frames("pp", 4);

        // Reset during a low data bit of 0x3C with two bytes queued.
        rx_q.delete(); st_q.delete();
        bus.tx_req_i = 1'b1; bus.tx_data_i = 8'h3C;
        @(negedge clk);
        bus.tx_data_i = 8'h01;
        @(negedge clk);
        bus.tx_data_i = 8'h02;
        @(negedge clk);
        bus.tx_req_i = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_pre_tx", tx_o, 1'b0);
        chk("mid_pre_cnt", fifo_cnt_o, 3'd2);
        arst_n = 1'b0;
        #1;
        chk("mid_async_tx", tx_o, 1'b1);
        chk("mid_async_cnt", fifo_cnt_o, 3'd0);
        chk("mid_async_busy", busy_o, 1'b0);
        chk("mid_async_ack", bus.tx_ack_o, 1'b1);
        repeat (3) @(negedge clk);
        arst_n   = 1'b1;
        low_seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_o !== 1'b1 || busy_o !== 1'b0) low_seen = 1'b1;
        end
        chk("mid_quiet_line", low_seen, 1'b0);
        chk("mid_quiet_cnt", fifo_cnt_o, 3'd0);
        chk("mid_no_frame", rx_q.size(), 0);
        bus.tx_req_i = 1'b1; bus.tx_data_i = 8'h5A;
        @(negedge clk);
        bus.tx_req_i = 1'b0;
        wait_idle(100, nbusy);
        exp_b[0] = 8'h5A;
        chk_frames("mid_after", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
